// File: rtl/writeback_arbiter.sv
// Write-side front end of the register bank: merges never-stalled ALU results with
// long-latency results held in an in-order queue, cancelling entries made stale by younger ALU writes.
module writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     regwrite,
  output logic [4:0]               wr,
  output logic [XLEN-1:0]          wd,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      q_rd_q   [DEPTH];
  logic [4:0]      q_rd_d   [DEPTH];
  logic [XLEN-1:0] q_data_q [DEPTH];
  logic [XLEN-1:0] q_data_d [DEPTH];
  logic [DEPTH-1:0] q_vld_q, q_vld_d;
  logic [DEPTH-1:0] occupied;

  logic            regwrite_q, regwrite_d;
  logic [4:0]      wr_q, wr_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic alu_sel;
  logic head_present;
  logic head_vld;
  logic mem_xfer;
  logic pop;
  logic bypass;
  logic push;

  function automatic logic [CW-1:0] slot_offset(input logic [PW-1:0] idx,
                                                input logic [PW-1:0] base);
    logic [PW-1:0] diff;
    diff = idx - base;
    return {1'b0, diff};
  endfunction

  assign mem_ready = reset && (count_q < CW'(DEPTH));

  // A slot is occupied when its distance from the head is below the occupancy count.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = (slot_offset(PW'(i), rd_ptr_q) < count_q);
    end
  end

  assign pending = |(q_vld_q & occupied);

  always_comb begin
    alu_sel      = alu_valid && (alu_rd != 5'd0);
    head_present = (count_q != '0);
    head_vld     = q_vld_q[rd_ptr_q];
    mem_xfer     = mem_valid && mem_ready;
    pop          = !alu_sel && head_present;
    bypass       = !alu_sel && !head_present && mem_xfer && (mem_rd != 5'd0);
    push         = mem_xfer && (mem_rd != 5'd0) && !bypass;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    q_rd_d   = q_rd_q;
    q_data_d = q_data_q;
    q_vld_d  = q_vld_q;

    if (alu_sel) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_rd_q[i] == alu_rd) begin
          q_vld_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      q_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    // The push slot never aliases the pop slot: pop needs a non-empty queue, push needs a free slot.
    if (push) begin
      q_rd_d[wr_ptr_q]   = mem_rd;
      q_data_d[wr_ptr_q] = mem_data;
      q_vld_d[wr_ptr_q]  = !(alu_sel && (mem_rd == alu_rd));
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    wr_d       = wr_q;
    wd_d       = wd_q;
    if (alu_sel) begin
      regwrite_d = 1'b1;
      wr_d       = alu_rd;
      wd_d       = alu_data;
    end else if (pop && head_vld) begin
      regwrite_d = 1'b1;
      wr_d       = q_rd_q[rd_ptr_q];
      wd_d       = q_data_q[rd_ptr_q];
    end else if (bypass) begin
      regwrite_d = 1'b1;
      wr_d       = mem_rd;
      wd_d       = mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      q_vld_q    <= '0;
      regwrite_q <= 1'b0;
      wr_q       <= '0;
      wd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_q[i]   <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      q_vld_q    <= q_vld_d;
      regwrite_q <= regwrite_d;
      wr_q       <= wr_d;
      wd_q       <= wd_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_q[i]   <= q_rd_d[i];
        q_data_q[i] <= q_data_d[i];
      end
    end
  end

  assign regwrite = regwrite_q;
  assign wr       = wr_q;
  assign wd       = wd_q;
  assign count    = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected register-bank writes,
// an independent monitor pops and compares every write the DUT presents.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            regwrite;
  logic [4:0]      wr;
  logic [XLEN-1:0] wd;
  logic            pending;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .regwrite(regwrite), .wr(wr), .wd(wd), .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // Monitor: every presented write must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (regwrite === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_write: got wr=%0d wd=0x%0h expected no write", wr, wd);
        end else begin
          e = exp_q.pop_front();
          if (wr !== e.rd || wd !== e.data) begin
            bad++;
            $display("[TB] FAIL write: got wr=%0d wd=0x%0h expected wr=%0d wd=0x%0h",
                     wr, wd, e.rd, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // Reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    end
    checkOutput("reset_regwrite", int'(regwrite), 0);
    checkOutput("reset_wr", int'(wr), 0);
    checkOutput("reset_wd", int'(wd), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_pending", int'(pending), 0);
    checkOutput("reset_mem_ready", int'(mem_ready), 0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    idle(1);
    checkOutput("release_mem_ready", int'(mem_ready), 1);

    // ALU only, then ALU to x0
    expectWrite(5'd5, 32'h3);
    applyStimulus(1'b1, 5'd5, 32'h3, 1'b0, 5'd0, '0);
    checkOutput("alu_wr", int'(wr), 5);
    applyStimulus(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, '0);
    checkOutput("alu_x0_regwrite", int'(regwrite), 0);

    // Bypass into an empty queue
    expectWrite(5'd7, 32'hAA);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hAA);
    checkOutput("bypass_count", int'(count), 0);
    checkOutput("bypass_regwrite", int'(regwrite), 1);

    // ALU wins, mem result queued and written next cycle
    expectWrite(5'd3, 32'h11);
    expectWrite(5'd7, 32'hAA);
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'hAA);
    checkOutput("queue_count", int'(count), 1);
    checkOutput("queue_pending", int'(pending), 1);
    idle(1);
    checkOutput("queue_drain_count", int'(count), 0);

    // Backpressure with sustained ALU traffic
    expectWrite(5'd1, 32'h101);
    expectWrite(5'd2, 32'h102);
    expectWrite(5'd4, 32'h104);
    expectWrite(5'd8, 32'h1);
    expectWrite(5'd9, 32'h2);
    expectWrite(5'd10, 32'h3);
    applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h1);
    checkOutput("bp_count1", int'(count), 1);
    applyStimulus(1'b1, 5'd2, 32'h102, 1'b1, 5'd9, 32'h2);
    checkOutput("bp_count2", int'(count), 2);
    checkOutput("bp_ready_low", int'(mem_ready), 0);
    applyStimulus(1'b1, 5'd4, 32'h104, 1'b1, 5'd10, 32'h3);
    checkOutput("bp_count_hold", int'(count), 2);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd10, 32'h3);
    checkOutput("bp_pop_count", int'(count), 1);
    checkOutput("bp_ready_back", int'(mem_ready), 1);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd10, 32'h3);
    checkOutput("bp_pushpop_count", int'(count), 1);
    checkOutput("bp_pending", int'(pending), 1);
    idle(1);
    checkOutput("bp_empty", int'(count), 0);

    // Cancellation of a queued entry by a younger ALU write
    expectWrite(5'd12, 32'hC);
    expectWrite(5'd6, 32'h99);
    applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd6, 32'h55);
    applyStimulus(1'b1, 5'd6, 32'h99, 1'b0, 5'd0, '0);
    checkOutput("cancel_count", int'(count), 1);
    checkOutput("cancel_pending", int'(pending), 0);
    idle(1);
    checkOutput("cancel_pop_regwrite", int'(regwrite), 0);
    checkOutput("cancel_pop_count", int'(count), 0);

    // Same-cycle transfer to the ALU's destination is stored cancelled
    expectWrite(5'd13, 32'h1);
    applyStimulus(1'b1, 5'd13, 32'h1, 1'b1, 5'd13, 32'h2);
    checkOutput("samecyc_count", int'(count), 1);
    checkOutput("samecyc_pending", int'(pending), 0);
    idle(1);
    checkOutput("samecyc_pop_count", int'(count), 0);

    // Transfer to x0 completes but stores nothing and writes nothing
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hDEAD);
    checkOutput("x0_mem_count", int'(count), 0);
    checkOutput("x0_mem_regwrite", int'(regwrite), 0);

    // Reset asserted with two valid entries queued
    expectWrite(5'd1, 32'h201);
    expectWrite(5'd2, 32'h202);
    applyStimulus(1'b1, 5'd1, 32'h201, 1'b1, 5'd14, 32'hE);
    applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd15, 32'hF);
    checkOutput("mid_count2", int'(count), 2);
    checkOutput("mid_pending", int'(pending), 1);
    @(negedge clk);
    #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_count", int'(count), 0);
    checkOutput("mid_reset_pending", int'(pending), 0);
    checkOutput("mid_reset_regwrite", int'(regwrite), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(4);
    checkOutput("post_reset_count", int'(count), 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
